// File: rtl/manch_pkg.sv
// Shared types and timing-window helpers for the Manchester demodulator.
// All window bounds derive from the half-bit length in clk cycles.
package manch_pkg;

  localparam int HALF_BIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] sync_lo(input int h);
    return 8'(2 * h - h / 2);
  endfunction

  function automatic logic [7:0] sync_hi(input int h);
    return 8'(2 * h + h / 2);
  endfunction

  function automatic logic [7:0] lock_lo(input int h);
    return 8'((3 * h) / 2);
  endfunction

  function automatic logic [7:0] lock_hi(input int h);
    return 8'((5 * h) / 2);
  endfunction

  function automatic logic [7:0] lock_timeout(input int h);
    return 8'((5 * h) / 2 + 1);
  endfunction

endpackage

// File: rtl/manch_demod_if.sv
// Line input, enable and decoded-bit outputs of the Manchester demodulator.
// master = line/enable driver, slave = demodulator.
interface manch_demod_if;
  logic in_enable;
  logic in_manch;
  logic out_data;
  logic out_valid;
  logic out_locked;
  logic out_err;

  modport master (
    output in_enable,
    output in_manch,
    input  out_data,
    input  out_valid,
    input  out_locked,
    input  out_err
  );

  modport slave (
    input  in_enable,
    input  in_manch,
    output out_data,
    output out_valid,
    output out_locked,
    output out_err
  );
endinterface

// File: rtl/manch_edge_det.sv
// Line synchronizer, optional 3-sample majority filter (MANCH_GLITCH_FILTER_EN), edge detect.
// Edge pulse 2 clk after a line change (3 with filter); no backpressure.
module manch_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_manch,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_manch;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MANCH_GLITCH_FILTER_EN
  logic r_hist1;
  logic r_hist2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist1 <= 1'b0;
      r_hist2 <= 1'b0;
    end else begin
      r_hist1 <= r_sync2;
      r_hist2 <= r_hist1;
    end
  end

  // A level must be seen on two of three consecutive samples to pass.
  assign w_line = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);
`else
  assign w_line = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_line;
    end
  end

  assign o_rise = w_line & ~r_prev;
  assign o_fall = ~w_line & r_prev;

endmodule

// File: rtl/manch_demod.sv
// Manchester demodulator: IDLE/SYNC/LOCKED FSM, interval counter, registered outputs.
// Line change to out_valid 3 clk (4 with MANCH_GLITCH_FILTER_EN); no backpressure.
module manch_demod
  import manch_pkg::*;
#(
  parameter int HALF_BIT = HALF_BIT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  manch_demod_if.slave bus
);

  localparam logic [7:0] SYNC_LO = sync_lo(HALF_BIT);
  localparam logic [7:0] SYNC_HI = sync_hi(HALF_BIT);
  localparam logic [7:0] LOCK_LO = lock_lo(HALF_BIT);
  localparam logic [7:0] LOCK_HI = lock_hi(HALF_BIT);
  localparam logic [7:0] LOCK_TO = lock_timeout(HALF_BIT);

  state_t     r_state;
  state_t     w_nxt_state;
  logic [7:0] r_cnt;
  logic [7:0] w_nxt_cnt;
  logic       r_data;
  logic       w_nxt_data;
  logic       r_valid;
  logic       w_nxt_valid;
  logic       r_err;
  logic       w_nxt_err;
  logic       r_locked;
  logic       w_rise;
  logic       w_fall;
  logic       w_edge;

  manch_edge_det u_edge_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_manch (bus.in_manch),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge = w_rise | w_fall;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_data  = r_data;
    w_nxt_valid = 1'b0;
    w_nxt_err   = 1'b0;
    if (!bus.in_enable) begin
      w_nxt_state = IDLE;
      w_nxt_cnt   = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_state = SYNC;
          w_nxt_cnt   = 8'd0;
        end
        SYNC: begin
          if (w_edge) begin
            w_nxt_cnt = 8'd0;
            // Only a full-bit gap identifies a mid-bit edge; half-bit gaps are ambiguous.
            if (r_cnt >= SYNC_LO && r_cnt <= SYNC_HI) begin
              w_nxt_data  = w_rise;
              w_nxt_valid = 1'b1;
              w_nxt_state = LOCKED;
            end
          end else if (r_cnt != 8'hFF) begin
            w_nxt_cnt = r_cnt + 8'd1;
          end
        end
        LOCKED: begin
          if (w_edge && r_cnt >= LOCK_LO && r_cnt <= LOCK_HI) begin
            w_nxt_data  = w_rise;
            w_nxt_valid = 1'b1;
            w_nxt_cnt   = 8'd0;
          end else if (r_cnt == LOCK_TO - 8'd1) begin
            w_nxt_err   = 1'b1;
            w_nxt_state = SYNC;
            w_nxt_cnt   = 8'd0;
          end else begin
            w_nxt_cnt = r_cnt + 8'd1;
          end
        end
        default: begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_data   <= w_nxt_data;
      r_valid  <= w_nxt_valid;
      r_err    <= w_nxt_err;
      r_locked <= (w_nxt_state == LOCKED);
    end
  end

  assign bus.out_data   = r_data;
  assign bus.out_valid  = r_valid;
  assign bus.out_locked = r_locked;
  assign bus.out_err    = r_err;

endmodule
